// File: rtl/parity_cmd_sequencer.sv
// Purpose: walks a 128B-aligned source buffer and issues one READ_CL_NA per line for a parity job.
// Latency: first command the cycle after an accepted start; peak rate one command per cycle.
// Backpressure: issue throttled by latched PSL room and a round-robin tag pool; the command port has none.
//
// Ports:
//   i_clock, i_reset_n           clock and synchronous active-low reset
//   i_start, i_abort             job start pulse / stop request
//   i_src_addr, i_line_count,    job parameters, sampled on an accepted start
//   i_room
//   o_cmd_*                      command strobe with code, tag, address and size
//   i_resp_*                     PSL response strobe with tag and code
//   o_busy, o_done, o_error,     job status
//   o_lines_completed
module parity_cmd_sequencer #(
    parameter int TAG_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 16,
    parameter int LINE_BYTES      = 128
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [63:0]          i_src_addr,
    input  logic [31:0]          i_line_count,
    input  logic [7:0]           i_room,
    output logic                 o_cmd_valid,
    output logic [12:0]          o_cmd_code,
    output logic [TAG_WIDTH-1:0] o_cmd_tag,
    output logic [63:0]          o_cmd_addr,
    output logic [11:0]          o_cmd_size,
    input  logic                 i_resp_valid,
    input  logic [TAG_WIDTH-1:0] i_resp_tag,
    input  logic [7:0]           i_resp_code,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [31:0]          o_lines_completed
);

    localparam int IDX_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [12:0] READ_CL_NA = 13'h0A00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [63:0]                r_cur_addr;
    logic [31:0]                r_line_count;
    logic [7:0]                 r_room;
    logic [31:0]                r_issued;
    logic [CNT_W-1:0]           r_outstanding;
    logic [MAX_OUTSTANDING-1:0] r_bitmap;
    logic [MAX_OUTSTANDING-1:0] w_bitmap_nxt;
    logic [IDX_W-1:0]           r_next_tag;
    logic                       r_error;
    logic [31:0]                r_lines_completed;

    logic [31:0] w_limit;
    logic        w_issue;
    logic        w_resp_active;
    logic        w_resp_known;
    logic        w_resp_ok;
    logic        w_resp_fail;

    // Effective credit window: the smaller of the latched PSL room and the tag pool.
    assign w_limit = ({24'd0, r_room} < 32'(MAX_OUTSTANDING)) ? {24'd0, r_room}
                                                               : 32'(MAX_OUTSTANDING);

    // Issue depends only on registered state, so the command port never
    // combinationally follows responses or abort in the same cycle.
    assign w_issue = (r_state == S_ISSUE)
                  && (r_issued < r_line_count)
                  && (32'(r_outstanding) < w_limit)
                  && !r_bitmap[r_next_tag];

    // Responses are ignored in IDLE so stale traffic from a reset job is harmless.
    assign w_resp_active = i_resp_valid && (r_state != S_IDLE);
    // Tags at or above the pool size can never be outstanding.
    assign w_resp_known  = w_resp_active
                        && (32'(i_resp_tag) < 32'(MAX_OUTSTANDING))
                        && r_bitmap[i_resp_tag[IDX_W-1:0]];
    assign w_resp_ok     = w_resp_known && (i_resp_code == 8'h00);
    // Covers both a failure code on a known tag and a stray tag.
    assign w_resp_fail   = w_resp_active && !w_resp_ok;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_ISSUE;
            S_ISSUE:  if (w_resp_fail || i_abort || (r_issued == r_line_count))
                          w_state_nxt = S_DRAIN;
            S_DRAIN:  if (r_outstanding == '0) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Retire and issue never touch the same bit: issue needs the tag free,
    // retire needs it set.
    always_comb begin
        w_bitmap_nxt = r_bitmap;
        if (w_resp_known) w_bitmap_nxt[i_resp_tag[IDX_W-1:0]] = 1'b0;
        if (w_issue)      w_bitmap_nxt[r_next_tag] = 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state           <= S_IDLE;
            r_cur_addr        <= '0;
            r_line_count      <= '0;
            r_room            <= '0;
            r_issued          <= '0;
            r_outstanding     <= '0;
            r_bitmap          <= '0;
            r_next_tag        <= '0;
            r_error           <= 1'b0;
            r_lines_completed <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_bitmap      <= w_bitmap_nxt;
            r_outstanding <= r_outstanding + CNT_W'(w_issue) - CNT_W'(w_resp_known);

            if ((r_state == S_IDLE) && i_start) begin
                // Bitmap and outstanding are already zero whenever IDLE is reached.
                r_cur_addr        <= i_src_addr;
                r_line_count      <= i_line_count;
                r_room            <= i_room;
                r_issued          <= '0;
                r_next_tag        <= '0;
                r_error           <= 1'b0;
                r_lines_completed <= '0;
            end

            if (w_issue) begin
                r_cur_addr <= r_cur_addr + 64'(LINE_BYTES);
                r_issued   <= r_issued + 32'd1;
                r_next_tag <= r_next_tag + IDX_W'(1);
            end

            if (w_resp_ok) r_lines_completed <= r_lines_completed + 32'd1;

            if (w_resp_fail || ((r_state == S_ISSUE) && i_abort)) r_error <= 1'b1;
        end
    end

    assign o_cmd_valid       = w_issue;
    assign o_cmd_code        = w_issue ? READ_CL_NA : '0;
    assign o_cmd_tag         = w_issue ? TAG_WIDTH'(r_next_tag) : '0;
    assign o_cmd_addr        = w_issue ? r_cur_addr : '0;
    assign o_cmd_size        = w_issue ? 12'(LINE_BYTES) : '0;
    assign o_busy            = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign o_done            = (r_state == S_FINISH);
    assign o_error           = r_error;
    assign o_lines_completed = r_lines_completed;

endmodule

// File: tb/tb_parity_cmd_sequencer.sv
module tb_parity_cmd_sequencer;
    localparam int TW = 8;
    localparam int MO = 16;
    localparam int LB = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [63:0]   src_addr = '0;
    logic [31:0]   line_count = '0;
    logic [7:0]    room = '0;
    logic          cmd_valid;
    logic [12:0]   cmd_code;
    logic [TW-1:0] cmd_tag;
    logic [63:0]   cmd_addr;
    logic [11:0]   cmd_size;
    logic          resp_valid = 1'b0;
    logic [TW-1:0] resp_tag = '0;
    logic [7:0]    resp_code = '0;
    logic          busy;
    logic          done;
    logic          error;
    logic [31:0]   lines_completed;

    always #5 clk = ~clk;

    parity_cmd_sequencer #(.TAG_WIDTH(TW), .MAX_OUTSTANDING(MO), .LINE_BYTES(LB)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort),
        .i_src_addr(src_addr), .i_line_count(line_count), .i_room(room),
        .o_cmd_valid(cmd_valid), .o_cmd_code(cmd_code), .o_cmd_tag(cmd_tag),
        .o_cmd_addr(cmd_addr), .o_cmd_size(cmd_size),
        .i_resp_valid(resp_valid), .i_resp_tag(resp_tag), .i_resp_code(resp_code),
        .o_busy(busy), .o_done(done), .o_error(error), .o_lines_completed(lines_completed)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference model: job-level view of the sequencer.
    bit          m_out[MO];
    int          m_cnt, m_idx, m_next, m_ok, m_lc, m_lim;
    bit          m_err, m_issuing, m_active;
    logic [63:0] m_base;

    // Responder and bookkeeping.
    int q_tag[$];
    int q_due[$];
    int g_mode = 0, g_delay = 1, g_nresp = 0, g_bad_nth = 0;
    int g_abort_cyc = -1, g_stray_cyc = -1;
    int g_start_cyc, g_first_cmd, g_done_cyc, g_last_resp_cyc;
    int g_ncmd, g_max_cnt, g_wraps, g_simul;
    bit g_done_seen;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        foreach (m_out[t]) m_out[t] = 1'b0;
        m_cnt = 0; m_idx = 0; m_next = 0; m_ok = 0;
        m_err = 1'b0; m_issuing = 1'b0; m_active = 1'b0;
        q_tag.delete(); q_due.delete();
    endtask

    // One clock cycle: check outputs against the model, advance the model
    // by this cycle's inputs, then cross the edge.
    task automatic cycle();
        bit exp_v;
        bit stop;
        int idx_pre;
        idx_pre = m_idx;
        stop = 1'b0;
        exp_v = m_issuing && (m_idx < m_lc) && (m_cnt < m_lim) && !m_out[m_next];
        chk("cmd_valid", cmd_valid, exp_v);
        if (cmd_valid === 1'b1) begin
            g_ncmd++;
            if (g_first_cmd < 0) g_first_cmd = cyc;
            if (resp_valid) g_simul++;
            chk("cmd_tag", cmd_tag, m_next);
            chk("cmd_addr", cmd_addr, m_base + 64'(m_idx) * LB);
            chk("cmd_code", cmd_code, 13'h0A00);
            chk("cmd_size", cmd_size, LB);
        end
        if (m_issuing) chk("busy_issue", busy, 1);
        chk("error", error, m_err);
        chk("lines", lines_completed, m_ok);
        if (done === 1'b1) begin
            chk("done_outstanding", m_cnt, 0);
            chk("done_busy", busy, 0);
            g_done_seen = 1'b1;
            g_done_cyc = cyc;
            m_active = 1'b0;
            m_issuing = 1'b0;
        end
        if (resp_valid) g_last_resp_cyc = cyc;
        if (resp_valid && m_active) begin
            if (int'(resp_tag) < MO && m_out[int'(resp_tag)]) begin
                m_out[int'(resp_tag)] = 1'b0;
                m_cnt--;
                if (resp_code == 8'h00) m_ok++;
                else begin m_err = 1'b1; stop = 1'b1; end
            end else begin
                m_err = 1'b1; stop = 1'b1;
            end
        end
        if (abort && m_issuing) begin m_err = 1'b1; stop = 1'b1; end
        if (exp_v) begin
            if (m_next == 0 && m_idx > 0) g_wraps++;
            m_out[m_next] = 1'b1;
            q_tag.push_back(m_next);
            q_due.push_back(cyc + g_delay);
            m_cnt++;
            m_idx++;
            m_next = (m_next + 1) % MO;
            if (m_cnt > g_max_cnt) g_max_cnt = m_cnt;
        end
        if (m_issuing && (idx_pre == m_lc || stop)) m_issuing = 1'b0;
        if (start && !m_active) begin
            m_base = src_addr; m_lc = int'(line_count);
            m_lim = (int'(room) < MO) ? int'(room) : MO;
            m_idx = 0; m_next = 0; m_ok = 0; m_err = 1'b0;
            m_active = 1'b1; m_issuing = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0; resp_valid = 1'b0; resp_tag = '0; resp_code = '0;
        cyc++;
    endtask

    task automatic start_job(logic [63:0] a, int lc, int rm);
        src_addr = a; line_count = 32'(lc); room = 8'(rm); start = 1'b1;
        q_tag.delete(); q_due.delete();
        g_nresp = 0; g_first_cmd = -1; g_start_cyc = cyc; g_done_seen = 1'b0;
        g_ncmd = 0; g_max_cnt = 0; g_wraps = 0; g_simul = 0; g_last_resp_cyc = -1;
        cycle();
    endtask

    task automatic run(int budget, bit need_done);
        int n;
        int cand[$];
        n = 0;
        while (!g_done_seen && n < budget) begin
            if (g_mode == 0) begin
                if (q_tag.size() > 0 && q_due[0] <= cyc) begin
                    resp_valid = 1'b1;
                    resp_tag = TW'(q_tag.pop_front());
                    void'(q_due.pop_front());
                    g_nresp++;
                    resp_code = (g_nresp == g_bad_nth) ? 8'h05 : 8'h00;
                end
            end else begin
                cand.delete();
                for (int t = 0; t < MO; t++) if (m_out[t]) cand.push_back(t);
                if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                    resp_valid = 1'b1;
                    resp_tag = TW'(cand[$urandom_range(0, cand.size() - 1)]);
                    resp_code = ($urandom_range(0, 39) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                end
                if (m_issuing && $urandom_range(0, 149) == 0) abort = 1'b1;
            end
            if (cyc == g_stray_cyc) begin resp_valid = 1'b1; resp_tag = 8'd9; resp_code = 8'h00; end
            if (cyc == g_abort_cyc) abort = 1'b1;
            cycle();
            n++;
        end
        if (need_done) chk("job_done", g_done_seen, 1);
        g_abort_cyc = -1; g_stray_cyc = -1; g_bad_nth = 0;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_code"}, cmd_code, 0);
        chk({tag, "_cmd_tag"}, cmd_tag, 0);
        chk({tag, "_cmd_addr"}, cmd_addr, 0);
        chk({tag, "_cmd_size"}, cmd_size, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_lines"}, lines_completed, 0);
    endtask

    initial begin
        model_clear();
        m_lc = 0; m_lim = 0; m_base = '0;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        cycle();

        // Basic run: four back-to-back commands, responses after issue completes
        g_mode = 0; g_delay = 8;
        start_job(64'h1000, 4, 64);
        run(200, 1);
        chk("basic_first_latency", g_first_cmd - g_start_cyc, 1);
        chk("basic_ncmd", g_ncmd, 4);
        chk("basic_done_latency", g_done_cyc - g_last_resp_cyc, 2);
        chk("basic_lines", lines_completed, 4);
        chk("basic_error", error, 0);
        repeat (2) cycle();

        // Credit throttle: room of 2, slow responses
        g_delay = 10;
        start_job(64'h2000, 5, 2);
        run(300, 1);
        chk("throttle_max_outstanding", g_max_cnt, 2);
        chk("throttle_lines", lines_completed, 5);

        // Tag wrap with a response every issue cycle, address wraps past 2^64
        g_delay = 1;
        start_job(64'hFFFF_FFFF_FFFF_F000, 40, 64);
        run(300, 1);
        chk("wrap_count", g_wraps, 2);
        chk("wrap_simultaneous", g_simul, 39);
        chk("wrap_lines", lines_completed, 40);
        chk("wrap_error", error, 0);

        // Failure on the third response
        g_delay = 4; g_bad_nth = 3;
        start_job(64'h8000, 8, 64);
        run(300, 1);
        chk("fail_ncmd", g_ncmd, 7);
        chk("fail_error", error, 1);
        chk("fail_lines", lines_completed, 6);

        // Abort after three issues (room caps it at three)
        g_delay = 10; g_abort_cyc = cyc + 6;
        start_job(64'h10000, 10, 3);
        run(300, 1);
        chk("abort_ncmd", g_ncmd, 3);
        chk("abort_error", error, 1);
        chk("abort_lines", lines_completed, 3);

        // Zero room stalls until abort
        g_abort_cyc = cyc + 5;
        start_job(64'h20000, 4, 0);
        run(100, 1);
        chk("room0_ncmd", g_ncmd, 0);
        chk("room0_error", error, 1);

        // Stray tag while tags 0-2 outstanding
        g_delay = 20; g_stray_cyc = cyc + 6;
        start_job(64'h30000, 6, 3);
        run(300, 1);
        chk("stray_ncmd", g_ncmd, 3);
        chk("stray_error", error, 1);
        chk("stray_lines", lines_completed, 3);

        // Reset mid-job with five outstanding
        g_delay = 1000;
        start_job(64'h40000, 10, 5);
        run(8, 0);
        chk("midreset_ncmd", g_ncmd, 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("midreset");
        rst_n = 1'b1;
        model_clear();
        for (int t = 0; t < 5; t++) begin
            resp_valid = 1'b1; resp_tag = TW'(t); resp_code = 8'h00;
            cycle();
        end
        chk("late_resp_error", error, 0);
        chk("late_resp_busy", busy, 0);

        // Zero-length job
        g_delay = 1;
        start_job(64'h50000, 0, 8);
        run(50, 1);
        chk("zero_done_latency", g_done_cyc - g_start_cyc, 3);
        chk("zero_error", error, 0);
        chk("zero_ncmd", g_ncmd, 0);

        // Randomized jobs with out-of-order responses, occasional failures and aborts
        g_mode = 1;
        for (int j = 0; j < 8; j++) begin
            start_job({$urandom, $urandom} & ~64'h7F, $urandom_range(0, 30), $urandom_range(1, 20));
            run(3000, 1);
            repeat ($urandom_range(0, 3)) cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/parity_cmd_sequencer.md
Name: parity_cmd_sequencer

Overview:
- Sequences PSL cache-line read commands for a parity job: from a start pulse it walks a 128-byte-aligned source buffer and issues one READ_CL_NA per line.
- Issue is throttled by PSL command credits (room) and a local tag pool; it retires PSL responses and reports done or error.
- Sits between the job control logic (start/abort) and the AFU command/response interfaces.

Parameters:
- TAG_WIDTH, 8, width of cmd_tag/resp_tag.
- MAX_OUTSTANDING, 16, tag pool size (power of 2, ≤ 2^TAG_WIDTH); tags used are 0..MAX_OUTSTANDING-1.
- LINE_BYTES, 128, bytes per command; address stride and cmd_size value.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle job start pulse
- abort  in  1  one-cycle stop request
- src_addr  in  64  buffer base, sampled on start; low 7 bits must be 0
- line_count  in  32  lines to read, sampled on start
- room  in  8  PSL command credits, sampled on start
- cmd_valid  out  1  command strobe; one cycle per command, no backpressure
- cmd_code  out  13  0x0A00 (READ_CL_NA) whenever cmd_valid
- cmd_tag  out  TAG_WIDTH  tag of issued command
- cmd_addr  out  64  src_addr + issued_index*LINE_BYTES, mod 2^64
- cmd_size  out  12  LINE_BYTES
- resp_valid  in  1  PSL response strobe
- resp_tag  in  TAG_WIDTH  response tag
- resp_code  in  8  0x00 = DONE; any other value is a failure
- busy  out  1  high from cycle after accepted start until done pulse
- done  out  1  one-cycle completion pulse (success, error or abort)
- error  out  1  sticky status, valid with done, cleared on next accepted start
- lines_completed  out  32  count of DONE responses in current job

Behaviour:
- Reset (reset_n=0 at edge): state IDLE; all outputs 0 (cmd_code, cmd_tag, cmd_addr, cmd_size also 0); outstanding bitmap, issued and completed counters cleared. Reset mid-job discards everything; later responses are ignored in IDLE.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: start accepted → latch inputs, clear error and lines_completed, → ISSUE. Start while not IDLE is ignored.
- ISSUE: a command is issued in a cycle iff issued < line_count AND outstanding < min(room_latched, MAX_OUTSTANDING) AND the next tag is free.
  - Tags are allocated round-robin; the next tag is (last+1) mod MAX_OUTSTANDING.
  - First command appears the cycle after start at earliest (latency 1).
  - Peak rate is 1 command/cycle.
  - room_latched=0 → nothing issues; the job stalls until abort.
- Outstanding count and bitmap update on the same edge for issue and retire.
  - Simultaneous issue and response gives a net-zero change and does not block issue.
  - Issue uses the pre-edge count.
- Response handling, any non-IDLE state:
  - resp_tag whose bitmap bit is set: clear the bit.
  - resp_code=0x00: lines_completed+1.
  - Nonzero code: set error, → DRAIN.
  - Response with a tag not outstanding: set error, no counter change, → DRAIN.
- ISSUE → DRAIN when issued == line_count, on abort, or on error. abort also sets error.
- DRAIN: no issue; waits until outstanding == 0, then → FINISH.
- FINISH: done=1 for one cycle, busy drops the same cycle, → IDLE.
- line_count=0: start(N) → ISSUE(N+1) → DRAIN(N+2) → done at N+3, error=0.
- Successful job: done asserts 2 cycles after the final response's edge. No outstanding tags remain when done is high.
- error stays valid after done until the next accepted start.

Test Plan:
- Basic run: src_addr=0x1000, line_count=4, room=64 → 4 back-to-back commands at 0x1000/0x1080/0x1100/0x1180, tags 0-3, cmd_size=128. All four respond DONE → done pulse, error=0, lines_completed=4.
- Credit throttle: room=2, line_count=5, responses delayed 10 cycles → never more than 2 outstanding. Issue resumes the cycle after each retire. 5 commands total, done, lines_completed=5.
- Tag wrap and simultaneity: MAX_OUTSTANDING=16, line_count=40, room=64, each response returned the same cycle as a new issue → tags wrap 15→0, no tag reused while outstanding, 40 completions, done.
- Failure: line_count=8, third response has resp_code=0x05 → no commands after that cycle, remaining outstanding responses drained, done with error=1, lines_completed counts only the DONE responses.
- Abort and stray tag: abort after 3 issues → issue stops, drain, done with error=1. Separately, resp_tag=9 when only tags 0-2 are outstanding → error=1, DRAIN.
- Reset mid-job and zero length: reset_n=0 with 5 outstanding → all outputs 0, IDLE, later responses produce no error. Next start with line_count=0 → done 3 cycles after start, error=0.
